// File: rtl/spi_dac_core.sv
// FPro slot core: queues per-channel 12-bit codes and serialises 16-bit frames
// to a 4-channel SPI DAC, with an optional LDAC-based simultaneous update.
module spi_dac_core #(
  parameter int SCLK_DIV = 4,
  parameter int HOLD_HP  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic        dac_din,
  output logic        dac_ldac_n
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_STOP  = 2'd2;
  localparam logic [1:0] ST_LDAC  = 2'd3;

  localparam logic [15:0] HALF_END  = 16'(SCLK_DIV - 1);
  localparam logic [15:0] STOP_END  = 16'(HOLD_HP * SCLK_DIV - 1);
  localparam logic [15:0] LDAC_END  = 16'(2 * SCLK_DIV - 1);
  localparam logic [5:0]  LAST_HALF = 6'd32;
  localparam logic [5:0]  BIT0_LOW  = 6'd31;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  half_q, half_d;
  logic [15:0] shift_q, shift_d;
  logic [1:0]  ch_q, ch_d;
  logic        sclk_q, sclk_d;
  logic        sync_n_q, sync_n_d;
  logic        din_q, din_d;
  logic        ldac_n_q, ldac_n_d;
  logic        busy_q, busy_d;
  logic [3:0]  pend_q, pend_d;
  logic        sim_q, sim_d;
  logic        req_q;
  logic        reload_q, reload_d;
  logic [11:0] code_q [4];

  logic        wr_en, wr_code, wr_ctrl, wr_all;
  logic        launch;
  logic [1:0]  ch_sel;
  logic [15:0] frame_w;
  logic        unused_ok;

  assign wr_en   = cs & write;
  assign wr_code = wr_en & ~addr[2];
  assign wr_ctrl = wr_en & (addr[2:0] == 3'd4);
  assign wr_all  = wr_en & (addr[2:0] == 3'd6);

  assign unused_ok = &{1'b0, read, addr[4:3], wr_data[31:12]};

  // req_q delays launch by one cycle so writes in back-to-back cycles are
  // arbitrated by channel index rather than by arrival order.
  assign launch = (state_q == ST_IDLE) && req_q && (pend_q != 4'd0);

  always_comb begin
    ch_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend_q[i]) ch_sel = 2'(i);
    end
  end

  assign frame_w = {ch_sel, 2'b00, code_q[ch_sel]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_code
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        code_q[gi] <= 12'd0;
      end else if (wr_code && (addr[1:0] == 2'(gi))) begin
        code_q[gi] <= wr_data[11:0];
      end
    end
  end

  // reload_q remembers a rewrite of the in-flight channel so STOP keeps it pending.
  always_comb begin
    pend_d   = pend_q;
    reload_d = reload_q;
    if (launch) begin
      reload_d = wr_all || (wr_code && (addr[1:0] == ch_sel));
    end else if (state_q == ST_SHIFT) begin
      reload_d = reload_q || wr_all || (wr_code && (addr[1:0] == ch_q));
    end
    if ((state_q == ST_STOP) && (cnt_q == 16'd0) && !reload_q) begin
      pend_d[ch_q] = 1'b0;
    end
    if (wr_code) pend_d[addr[1:0]] = 1'b1;
    if (wr_all)  pend_d = 4'hF;
  end

  assign sim_d = wr_ctrl ? wr_data[0] : sim_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    half_d   = half_q;
    shift_d  = shift_q;
    ch_d     = ch_q;
    sclk_d   = sclk_q;
    sync_n_d = sync_n_q;
    din_d    = din_q;
    ldac_n_d = sim_q;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d  = ST_SHIFT;
          ch_d     = ch_sel;
          shift_d  = frame_w;
          sync_n_d = 1'b0;
          sclk_d   = 1'b1;
          din_d    = frame_w[15];
          busy_d   = 1'b1;
          cnt_d    = 16'd0;
          half_d   = 6'd0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == HALF_END) begin
          cnt_d  = 16'd0;
          half_d = half_q + 6'd1;
          if (half_q == LAST_HALF) begin
            sync_n_d = 1'b1;
            state_d  = ST_STOP;
          end else if (!half_q[0]) begin
            sclk_d = 1'b0;
          end else if (half_q == BIT0_LOW) begin
            sclk_d = 1'b1;
            din_d  = 1'b0;
          end else begin
            sclk_d  = 1'b1;
            din_d   = shift_q[14];
            shift_d = {shift_q[14:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == STOP_END) begin
          cnt_d = 16'd0;
          if (pend_d != 4'd0) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else if (sim_q) begin
            state_d  = ST_LDAC;
            ldac_n_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        ldac_n_d = 1'b0;
        if (cnt_q == LDAC_END) begin
          cnt_d    = 16'd0;
          ldac_n_d = sim_q;
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 16'd0;
      half_q   <= 6'd0;
      shift_q  <= 16'd0;
      ch_q     <= 2'd0;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      din_q    <= 1'b0;
      ldac_n_q <= 1'b0;
      busy_q   <= 1'b0;
      pend_q   <= 4'd0;
      sim_q    <= 1'b0;
      req_q    <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      shift_q  <= shift_d;
      ch_q     <= ch_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      din_q    <= din_d;
      ldac_n_q <= ldac_n_d;
      busy_q   <= busy_d;
      pend_q   <= pend_d;
      sim_q    <= sim_d;
      req_q    <= (pend_q != 4'd0);
      reload_q <= reload_d;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (addr[2:0])
      3'd0, 3'd1, 3'd2, 3'd3: rd_data = {20'd0, code_q[addr[1:0]]};
      3'd4:                   rd_data = {31'd0, sim_q};
      3'd5:                   rd_data = {27'd0, pend_q, busy_q};
      default:                rd_data = 32'd0;
    endcase
  end

  assign dac_sclk   = sclk_q;
  assign dac_sync_n = sync_n_q;
  assign dac_din    = din_q;
  assign dac_ldac_n = ldac_n_q;

endmodule

// File: tb/tb_spi_dac_core.sv
// Directed bench for spi_dac_core: frame contents/timing, queueing, sim-mode LDAC,
// rewrite and set-wins corner cases, and asynchronous reset mid-frame.
module tb_spi_dac_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [4:0]  addr = 5'd5;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] rd_data;
  logic        dac_sclk, dac_sync_n, dac_din, dac_ldac_n;

  int checks = 0;
  int errors = 0;

  spi_dac_core #(.SCLK_DIV(4), .HOLD_HP(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .dac_sclk   (dac_sclk),
    .dac_sync_n (dac_sync_n),
    .dac_din    (dac_din),
    .dac_ldac_n (dac_ldac_n)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; addr = 5'd5; wr_data = 32'd0;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; addr = a;
    #1;
    d = rd_data;
    cs = 1'b0; read = 1'b0; addr = 5'd5;
  endtask

  // Samples on clk negedges: counts sync_n-high cycles before the frame, then
  // shifts in din on each sclk fall while sync_n is low. Returns at the first
  // sample that sees sync_n high again.
  task automatic capture(output logic [15:0] word, output int low_cyc, output int gap,
                         output bit ldac_hi, output bit ldac_lo, output bit busy_all,
                         output bit ok);
    int   t;
    logic prev_sclk;
    word = 16'd0; low_cyc = 0; gap = 0; ldac_hi = 0; ldac_lo = 0; busy_all = 1; ok = 0;
    t = 0;
    while (dac_sync_n === 1'b1 && t < 2000) begin
      if (dac_ldac_n === 1'b1) ldac_hi = 1;
      if (dac_ldac_n === 1'b0) ldac_lo = 1;
      gap++; t++;
      @(negedge clk);
    end
    if (t >= 2000) return;
    prev_sclk = dac_sclk;
    while (dac_sync_n === 1'b0 && t < 4000) begin
      if (dac_ldac_n === 1'b1) ldac_hi = 1;
      if (dac_ldac_n === 1'b0) ldac_lo = 1;
      if (rd_data[0] !== 1'b1) busy_all = 0;
      if (prev_sclk === 1'b1 && dac_sclk === 1'b0) word = {word[14:0], dac_din};
      prev_sclk = dac_sclk;
      low_cyc++; t++;
      @(negedge clk);
    end
    ok = (t < 4000);
    $display("frame word=%h sync_low=%0d gap=%0d", word, low_cyc, gap);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (2) @(negedge clk);
    checks++; if (dac_sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk got=%b exp=1", dac_sclk); end
    checks++; if (dac_sync_n !== 1'b1) begin errors++; $display("FAIL reset_sync got=%b exp=1", dac_sync_n); end
    checks++; if (dac_din !== 1'b0) begin errors++; $display("FAIL reset_din got=%b exp=0", dac_din); end
    checks++; if (dac_ldac_n !== 1'b0) begin errors++; $display("FAIL reset_ldac got=%b exp=0", dac_ldac_n); end
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus_read(5'(a), d);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=0", a, d); end
    end
    repeat (4) @(negedge clk);
    checks++; if (dac_sync_n !== 1'b1) begin errors++; $display("FAIL reset_noframe got=%b exp=1", dac_sync_n); end
  endtask

  task automatic test_single_frame();
    logic [15:0] w; int lo, gap; bit lhi, llo, ball, ok;
    logic [31:0] d;
    bus_write(5'd2, 32'h0000_0ABC);
    capture(w, lo, gap, lhi, llo, ball, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=0 exp=1"); end
    checks++; if (w !== 16'h8ABC) begin errors++; $display("FAIL single_word got=%h exp=8abc", w); end
    checks++; if (lo != 132) begin errors++; $display("FAIL single_synclow got=%0d exp=132", lo); end
    checks++; if (!ball) begin errors++; $display("FAIL single_busy got=0 exp=1"); end
    checks++; if (lhi) begin errors++; $display("FAIL single_ldac got=high exp=low"); end
    repeat (12) @(negedge clk);
    bus_read(5'd5, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL single_status got=%h exp=0", d); end
    bus_read(5'd2, d);
    checks++; if (d !== 32'h0000_0ABC) begin errors++; $display("FAIL single_code got=%h exp=abc", d); end
  endtask

  task automatic test_queue_order();
    logic [15:0] w; int lo, gap; bit lhi, llo, ball, ok;
    logic [31:0] d;
    bus_write(5'd3, 32'h0000_0FFF);
    bus_write(5'd1, 32'h0000_0123);
    capture(w, lo, gap, lhi, llo, ball, ok);
    checks++; if (!ok || w !== 16'h4123) begin errors++; $display("FAIL queue_first got=%h exp=4123", w); end
    capture(w, lo, gap, lhi, llo, ball, ok);
    checks++; if (!ok || w !== 16'hCFFF) begin errors++; $display("FAIL queue_second got=%h exp=cfff", w); end
    checks++; if (gap < 9) begin errors++; $display("FAIL queue_gap got=%0d exp>=9", gap); end
    checks++; if (lo != 132) begin errors++; $display("FAIL queue_synclow got=%0d exp=132", lo); end
    repeat (12) @(negedge clk);
    bus_read(5'd5, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL queue_status got=%h exp=0", d); end
  endtask

  task automatic test_sim_mode();
    logic [15:0] w; int lo, gap, t, pulse, bad; bit lhi, llo, ball, ok;
    logic [31:0] d;
    logic [15:0] exp_w [4];
    exp_w[0] = 16'h0000; exp_w[1] = 16'h4123; exp_w[2] = 16'h8ABC; exp_w[3] = 16'hCFFF;
    bus_write(5'd4, 32'd1);
    bus_read(5'd4, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL sim_ctrl got=%h exp=1", d); end
    repeat (2) @(negedge clk);
    checks++; if (dac_ldac_n !== 1'b1) begin errors++; $display("FAIL sim_idle_ldac got=%b exp=1", dac_ldac_n); end
    bus_write(5'd6, 32'd0);
    for (int k = 0; k < 4; k++) begin
      capture(w, lo, gap, lhi, llo, ball, ok);
      checks++; if (!ok || w !== exp_w[k]) begin errors++; $display("FAIL sim_frame%0d got=%h exp=%h", k, w, exp_w[k]); end
      checks++; if (llo) begin errors++; $display("FAIL sim_early_ldac%0d got=low exp=high", k); end
    end
    t = 0;
    while (dac_ldac_n === 1'b1 && t < 100) begin t++; @(negedge clk); end
    pulse = 0;
    while (dac_ldac_n === 1'b0 && pulse < 100) begin pulse++; @(negedge clk); end
    checks++; if (pulse != 8) begin errors++; $display("FAIL sim_ldac_width got=%0d exp=8", pulse); end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (dac_ldac_n !== 1'b1 || dac_sync_n !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL sim_after_pulse got=%0d exp=0", bad); end
    bus_write(5'd4, 32'd0);
    repeat (3) @(negedge clk);
    checks++; if (dac_ldac_n !== 1'b0) begin errors++; $display("FAIL sim_off_ldac got=%b exp=0", dac_ldac_n); end
  endtask

  task automatic test_midframe_rewrite();
    logic [15:0] w; int lo, gap; bit lhi, llo, ball, ok;
    logic [31:0] d;
    bus_write(5'd0, 32'h0000_0111);
    fork
      capture(w, lo, gap, lhi, llo, ball, ok);
      begin
        repeat (40) @(negedge clk);
        bus_write(5'd0, 32'h0000_0222);
      end
    join
    checks++; if (!ok || w !== 16'h0111) begin errors++; $display("FAIL rewrite_first got=%h exp=0111", w); end
    capture(w, lo, gap, lhi, llo, ball, ok);
    checks++; if (!ok || w !== 16'h0222) begin errors++; $display("FAIL rewrite_second got=%h exp=0222", w); end
    repeat (12) @(negedge clk);
    bus_read(5'd5, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rewrite_status got=%h exp=0", d); end
  endtask

  task automatic test_set_wins();
    logic [15:0] w; int lo, gap; bit lhi, llo, ball, ok;
    logic [31:0] d;
    bus_write(5'd0, 32'h0000_05A5);
    capture(w, lo, gap, lhi, llo, ball, ok);
    checks++; if (!ok || w !== 16'h05A5) begin errors++; $display("FAIL setwins_first got=%h exp=05a5", w); end
    bus_write(5'd0, 32'h0000_05A6);
    bus_read(5'd5, d);
    checks++; if (d !== 32'h0000_0003) begin errors++; $display("FAIL setwins_status got=%h exp=3", d); end
    capture(w, lo, gap, lhi, llo, ball, ok);
    checks++; if (!ok || w !== 16'h05A6) begin errors++; $display("FAIL setwins_second got=%h exp=05a6", w); end
    repeat (12) @(negedge clk);
    bus_read(5'd5, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL setwins_end got=%h exp=0", d); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    int t, lows;
    bus_write(5'd4, 32'd1);
    repeat (2) @(negedge clk);
    checks++; if (dac_ldac_n !== 1'b1) begin errors++; $display("FAIL rst_pre_ldac got=%b exp=1", dac_ldac_n); end
    bus_write(5'd1, 32'h0000_0777);
    t = 0;
    while (dac_sync_n !== 1'b0 && t < 100) begin t++; @(negedge clk); end
    checks++; if (t >= 100) begin errors++; $display("FAIL rst_no_frame got=timeout exp=frame"); end
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (dac_sync_n !== 1'b1) begin errors++; $display("FAIL rst_sync got=%b exp=1", dac_sync_n); end
    checks++; if (dac_sclk !== 1'b1) begin errors++; $display("FAIL rst_sclk got=%b exp=1", dac_sclk); end
    checks++; if (dac_din !== 1'b0) begin errors++; $display("FAIL rst_din got=%b exp=0", dac_din); end
    checks++; if (dac_ldac_n !== 1'b0) begin errors++; $display("FAIL rst_ldac got=%b exp=0", dac_ldac_n); end
    for (int a = 0; a < 8; a++) begin
      bus_read(5'(a), d);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_reg%0d got=%h exp=0", a, d); end
    end
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      if (dac_sync_n !== 1'b1) lows++;
      @(negedge clk);
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL rst_after got=%0d exp=0", lows); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_queue_order();
    test_sim_mode();
    test_midframe_rewrite();
    test_set_wins();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
